// File: rtl/sample_fifo_ctl_if.sv
// Bus bundle for the capture-path sample FIFO: producer/consumer controls, data, status and error counts.
interface sample_fifo_ctl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   af_thresh;
  logic [ADDR_W:0]   ae_thresh;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  ovf_count;
  logic [CNT_W-1:0]  udf_count;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    input  rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
           overflow, underflow, ovf_count, udf_count
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
    output rd_data, rd_valid, level, full, empty, almost_full, almost_empty,
           overflow, underflow, ovf_count, udf_count
  );
endinterface

// File: rtl/sample_fifo_ctl.sv
// Sample FIFO with thresholds, flush, sticky error flags; saturating error counters under OSC_FIFO_ERRCNT_EN.
// Latency: 1 clock from accepted rd_en to rd_data/rd_valid; flags decode from registered pointers only.
// Backpressure: writes while full (without a read) are dropped and flagged; reads while empty are rejected.
module sample_fifo_ctl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sample_fifo_ctl_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [ADDR_W:0] level;
  logic            full, empty;
  logic            wr_acc, rd_acc, wr_rej, rd_rej;

  assign level  = wr_ptr_q - rd_ptr_q;
  assign full   = (level == DEPTH_L);
  assign empty  = (level == '0);

  // When full, a concurrent read frees the very slot the write lands in.
  assign wr_acc = bus.wr_en && (!full || bus.rd_en);
  assign rd_acc = bus.rd_en && !empty;
  assign wr_rej = bus.wr_en && full && !bus.rd_en;
  assign rd_rej = bus.rd_en && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem[rd_ptr_q[ADDR_W-1:0]];
        rd_valid_d = 1'b1;
      end
      if (wr_rej) overflow_d  = 1'b1;
      if (rd_rej) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!bus.flush && wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
  end

`ifdef OSC_FIFO_ERRCNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] udf_cnt_q, udf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (!bus.flush && wr_rej && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (!bus.flush && rd_rej && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign bus.ovf_count = ovf_cnt_q;
  assign bus.udf_count = udf_cnt_q;
`else
  assign bus.ovf_count = '0;
  assign bus.udf_count = '0;
`endif

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.level        = level;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= bus.af_thresh);
  assign bus.almost_empty = (level <= bus.ae_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sample_fifo_ctl.sv
// Bench for sample_fifo_ctl: directed scenarios plus random traffic against a queue-based reference model.
module tb_sample_fifo_ctl;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sample_fifo_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  sample_fifo_ctl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data;
  bit                m_vld, m_ovf, m_udf;
  int                m_oc, m_uc;

  function automatic int exp_cnt(int c);
`ifdef OSC_FIFO_ERRCNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data = '0;
    m_vld = 0; m_ovf = 0; m_udf = 0;
    m_oc = 0; m_uc = 0;
  endtask

  task automatic model_clk(bit f, bit w, logic [DATA_W-1:0] d, bit r);
    int n;
    n = q.size();
    m_vld = 0;
    if (f) begin
      q.delete();
      m_ovf = 0; m_udf = 0;
    end else begin
      if (r && n > 0) begin
        m_rd_data = q.pop_front();
        m_vld = 1;
      end
      if (w && (n < DEPTH || r)) q.push_back(d);
      if (w && n == DEPTH && !r) begin
        m_ovf = 1;
        if (m_oc < CMAX) m_oc++;
      end
      if (r && n == 0) begin
        m_udf = 1;
        if (m_uc < CMAX) m_uc++;
      end
    end
  endtask

  task automatic check_all(string tag);
    int n;
    n = q.size();
    chk({tag, ".level"},    bus.level, n);
    chk({tag, ".full"},     bus.full, n == DEPTH);
    chk({tag, ".empty"},    bus.empty, n == 0);
    chk({tag, ".afull"},    bus.almost_full, n >= int'(bus.af_thresh));
    chk({tag, ".aempty"},   bus.almost_empty, n <= int'(bus.ae_thresh));
    chk({tag, ".rd_data"},  bus.rd_data, m_rd_data);
    chk({tag, ".rd_valid"}, bus.rd_valid, m_vld);
    chk({tag, ".ovf"},      bus.overflow, m_ovf);
    chk({tag, ".udf"},      bus.underflow, m_udf);
    chk({tag, ".ovf_cnt"},  bus.ovf_count, exp_cnt(m_oc));
    chk({tag, ".udf_cnt"},  bus.udf_count, exp_cnt(m_uc));
  endtask

  // Inputs change 1 time unit after an edge; outputs are checked at the same point.
  task automatic step(string tag, bit f, bit w, logic [DATA_W-1:0] d, bit r);
    bus.flush   = f;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    model_clk(f, w, d, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pw, pr;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.af_thresh = '0;
    bus.ae_thresh = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.afull_at_zero", bus.almost_full, 1'b1);
    #1 rst_n = 1'b1;

    // 1: fill with 1..8, then drain in order
    bus.af_thresh = 4'd8;
    bus.ae_thresh = 4'd0;
    for (int i = 1; i <= DEPTH; i++) step("t1_wr", 0, 1, 12'(i), 0);
    chk("t1.full_after_8", bus.full, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      step("t1_rd", 0, 0, '0, 1);
      chk("t1.data_order", bus.rd_data, i);
    end
    chk("t1.empty_after_8", bus.empty, 1'b1);

    // 2: overflow on full, original data survives
    for (int i = 0; i < DEPTH; i++) step("t2_fill", 0, 1, 12'h100 + 12'(i), 0);
    step("t2_ovf", 0, 1, 12'hABC, 0);
    chk("t2.overflow", bus.overflow, 1'b1);
    chk("t2.level8", bus.level, 8);
    for (int i = 0; i < DEPTH; i++) begin
      step("t2_drain", 0, 0, '0, 1);
      chk("t2.orig_data", bus.rd_data, 12'h100 + i);
    end

    // 3: simultaneous read/write on empty: write only, no fall-through
    step("t3_both", 0, 1, 12'h055, 1);
    chk("t3.rd_valid0", bus.rd_valid, 1'b0);
    chk("t3.underflow", bus.underflow, 1'b1);
    step("t3_rd", 0, 0, '0, 1);
    chk("t3.data", bus.rd_data, 12'h055);
    step("t3_flush", 1, 0, '0, 0);

    // 4: full FIFO, read+write every cycle, pointers wrap
    for (int i = 0; i < DEPTH; i++) step("t4_fill", 0, 1, 12'h200 + 12'(i), 0);
    for (int i = 0; i < 20; i++) step("t4_rw", 0, 1, 12'h300 + 12'(i), 1);
    chk("t4.no_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("t4_drain", 0, 0, '0, 1);

    // 5: threshold flags over fill and drain
    bus.af_thresh = 4'd6;
    bus.ae_thresh = 4'd2;
    for (int i = 0; i < DEPTH; i++) step("t5_fill", 0, 1, 12'(i), 0);
    for (int i = 0; i < DEPTH; i++) step("t5_drain", 0, 0, '0, 1);

    // counter saturation: 20 dropped writes and 20 empty reads
    for (int i = 0; i < DEPTH; i++) step("sat_fill", 0, 1, 12'(i), 0);
    for (int i = 0; i < 20; i++) step("sat_ovf", 0, 1, 12'hFFF, 0);
    for (int i = 0; i < DEPTH; i++) step("sat_drain", 0, 0, '0, 1);
    for (int i = 0; i < 20; i++) step("sat_udf", 0, 0, '0, 1);

    // 6: flush with 5 words loaded, counters hold
    for (int i = 0; i < 5; i++) step("t6_load", 0, 1, 12'h400 + 12'(i), 0);
    step("t6_flush", 1, 0, '0, 0);
    chk("t6.level0", bus.level, 0);
    step("t6_after", 0, 1, 12'h4AA, 0);

    // 6b: asynchronous reset mid-write
    bus.wr_en   = 1'b1;
    bus.wr_data = 12'h777;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    #2 rst_n = 1'b1;
    step("post_rst_wr", 0, 1, 12'h123, 0);
    step("post_rst_rd", 0, 0, '0, 1);
    chk("post_rst.data", bus.rd_data, 12'h123);

    // random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 75) % 2 == 0) ? 7 : 3;
      pr = 10 - pw;
      if ($urandom_range(0, 15) == 0) bus.af_thresh = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.ae_thresh = 4'($urandom_range(0, 15));
      step("rand",
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < pw,
           12'($urandom),
           $urandom_range(0, 9) < pr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
